// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA memory-side port.
// Holds the port state encoding, nibble ordering and the handshake helper.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LO,
    ST_WR_HI,
    ST_RD_FETCH,
    ST_RD_LO,
    ST_RD_HI,
    ST_DONE
  } port_state_t;

  localparam bit NIB_LO_FIRST = 1'b1;

  function automatic logic fire(input logic valid, input logic enable);
    return valid & enable;
  endfunction

endpackage

// File: rtl/dma_mem_port_if.sv
// Descriptor, nibble-stream and status signals between the DMA engine and
// the memory-side port. The DMA drives the master side, the port the slave side.
interface dma_mem_port_if #(
  parameter int LEN_W = 32
);

  logic             mode;
  logic             addr_in_valid;
  logic             addr_in_enable;
  logic [31:0]      addr_in;
  logic [LEN_W-1:0] len_in;
  logic             dma_to_mem_valid;
  logic             dma_to_mem_enable;
  logic [3:0]       mem_in_socket;
  logic             mem_to_dma_valid;
  logic             mem_to_dma_enable;
  logic [3:0]       mem_out_socket;
  logic             busy;
  logic             done;

  modport master (
    output mode, addr_in_valid, addr_in, len_in,
    output dma_to_mem_valid, mem_in_socket, mem_to_dma_enable,
    input  addr_in_enable, dma_to_mem_enable, mem_to_dma_valid,
    input  mem_out_socket, busy, done
  );

  modport slave (
    input  mode, addr_in_valid, addr_in, len_in,
    input  dma_to_mem_valid, mem_in_socket, mem_to_dma_enable,
    output addr_in_enable, dma_to_mem_enable, mem_to_dma_valid,
    output mem_out_socket, busy, done
  );

endinterface

// File: rtl/mem_byte_ram.sv
// Single-port byte RAM with synchronous write and one-cycle registered read.
// Contents are deliberately not reset; the read register only updates on i_re.
module mem_byte_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/dma_mem_port.sv
// Memory-side DMA endpoint: takes a descriptor, then packs incoming nibbles
// into RAM bytes (write mode) or unpacks RAM bytes into outgoing nibbles (read mode).
module dma_mem_port
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 32
) (
  input  logic         clk,
  input  logic         resetn,
  dma_mem_port_if.slave bus
);

  port_state_t       r_state;
  port_state_t       w_stateNext;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic [3:0]        r_nibLo;

  logic r_addrInEnable;
  logic r_dmaToMemEnable;
  logic r_memToDmaValid;
  logic r_busy;
  logic r_done;

  logic       w_descFire;
  logic       w_wrFire;
  logic       w_rdFire;
  logic       w_byteDone;
  logic       w_ramWe;
  logic       w_ramRe;
  logic [7:0] w_wrByte;
  logic [7:0] w_ramQ;
  logic       w_unusedAddrHi;

  assign w_unusedAddrHi = ^bus.addr_in[31:ADDR_W];

  // Handshakes are qualified by the registered enables, never by raw state.
  assign w_descFire = fire(bus.addr_in_valid, r_addrInEnable);
  assign w_wrFire   = fire(bus.dma_to_mem_valid, r_dmaToMemEnable);
  assign w_rdFire   = fire(bus.mem_to_dma_enable, r_memToDmaValid);

  assign w_wrByte = NIB_LO_FIRST ? {bus.mem_in_socket, r_nibLo}
                                 : {r_nibLo, bus.mem_in_socket};

  always_comb begin
    w_stateNext = r_state;
    w_ramWe     = 1'b0;
    w_ramRe     = 1'b0;
    w_byteDone  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_descFire) begin
          if (bus.len_in == '0) begin
            w_stateNext = ST_DONE;
          end else if (bus.mode) begin
            w_stateNext = ST_WR_LO;
          end else begin
            w_stateNext = ST_RD_FETCH;
          end
        end
      end
      ST_WR_LO: begin
        if (w_wrFire) begin
          w_stateNext = ST_WR_HI;
        end
      end
      ST_WR_HI: begin
        if (w_wrFire) begin
          w_ramWe     = 1'b1;
          w_byteDone  = 1'b1;
          w_stateNext = (r_remain == LEN_W'(1)) ? ST_DONE : ST_WR_LO;
        end
      end
      ST_RD_FETCH: begin
        w_ramRe     = 1'b1;
        w_stateNext = ST_RD_LO;
      end
      ST_RD_LO: begin
        if (w_rdFire) begin
          w_stateNext = ST_RD_HI;
        end
      end
      ST_RD_HI: begin
        if (w_rdFire) begin
          w_byteDone  = 1'b1;
          w_stateNext = (r_remain == LEN_W'(1)) ? ST_DONE : ST_RD_FETCH;
        end
      end
      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // r_state while still coming out of reset at zero.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state          <= ST_IDLE;
      r_addr           <= '0;
      r_remain         <= '0;
      r_nibLo          <= '0;
      r_addrInEnable   <= 1'b0;
      r_dmaToMemEnable <= 1'b0;
      r_memToDmaValid  <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_state          <= w_stateNext;
      r_addrInEnable   <= (w_stateNext == ST_IDLE);
      r_dmaToMemEnable <= (w_stateNext == ST_WR_LO) || (w_stateNext == ST_WR_HI);
      r_memToDmaValid  <= (w_stateNext == ST_RD_LO) || (w_stateNext == ST_RD_HI);
      r_busy           <= (w_stateNext != ST_IDLE);
      r_done           <= (w_stateNext == ST_DONE);
      if (w_descFire) begin
        r_addr   <= bus.addr_in[ADDR_W-1:0];
        r_remain <= bus.len_in;
      end else if (w_byteDone) begin
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
      if ((r_state == ST_WR_LO) && w_wrFire) begin
        r_nibLo <= bus.mem_in_socket;
      end
    end
  end

  mem_byte_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ramWe),
    .i_re   (w_ramRe),
    .i_addr (r_addr),
    .i_wdata(w_wrByte),
    .o_rdata(w_ramQ)
  );

  // The read byte sits in the RAM output register, so the selected nibble
  // stays stable for as long as the DMA stalls.
  always_comb begin
    bus.mem_out_socket = 4'h0;
    case (r_state)
      ST_RD_LO: bus.mem_out_socket = NIB_LO_FIRST ? w_ramQ[3:0] : w_ramQ[7:4];
      ST_RD_HI: bus.mem_out_socket = NIB_LO_FIRST ? w_ramQ[7:4] : w_ramQ[3:0];
      default:  bus.mem_out_socket = 4'h0;
    endcase
  end

  assign bus.addr_in_enable    = r_addrInEnable;
  assign bus.dma_to_mem_enable = r_dmaToMemEnable;
  assign bus.mem_to_dma_valid  = r_memToDmaValid;
  assign bus.busy              = r_busy;
  assign bus.done              = r_done;

endmodule

// File: doc/dma_mem_port.md
# dma_mem_port

Memory-side endpoint of the DMA datapath. It accepts an address/length descriptor from the DMA over the address handshake, then either absorbs a 4-bit nibble stream from the DMA into a byte-wide RAM (write mode) or streams RAM bytes back to the DMA as nibbles (read mode). It replaces the random-stimulus memory model with a deterministic, checkable store.

## Interface
- ADDR_W, 8, byte address width; RAM depth is 2^ADDR_W bytes.
- LEN_W, 32, width of the length field, in bytes.

- clk  in  1  sole clock; all logic on rising edge.
- resetn  in  1  one clock; reset is synchronous and active-high (resetn=1 resets).
- mode  in  1  1 = write (DMA→mem), 0 = read (mem→DMA); sampled only at descriptor accept.
- addr_in_valid  in  1  DMA presents a valid descriptor.
- addr_in_enable  out  1  port can accept a descriptor.
- addr_in  in  32  start byte address; only [ADDR_W-1:0] used.
- len_in  in  LEN_W  transfer length in bytes.
- dma_to_mem_valid  in  1  write nibble valid.
- dma_to_mem_enable  out  1  port can accept a write nibble.
- mem_in_socket  in  4  write nibble.
- mem_to_dma_valid  out  1  read nibble valid.
- mem_to_dma_enable  in  1  DMA accepts the read nibble.
- mem_out_socket  out  4  read nibble.
- busy  out  1  transfer in progress (any state but IDLE).
- done  out  1  one-cycle pulse at transfer completion.

## Operation
- States: IDLE, WR_LO, WR_HI, RD_FETCH, RD_LO, RD_HI, DONE.
- IDLE: addr_in_enable=1. On addr_in_valid&addr_in_enable, latch addr, len and mode.
  - If len=0: go to DONE.
  - Else if mode=1: go to WR_LO.
  - Else: go to RD_FETCH.
- WR_LO/WR_HI: dma_to_mem_enable=1.
  - A handshake in WR_LO stores the nibble in low holding bits.
  - A handshake in WR_HI writes {nibble, low} to ram[addr], increments addr, decrements remaining.
  - After the WR_HI handshake: go to DONE if remaining becomes 0, else WR_LO.
- RD_FETCH: issue a synchronous RAM read of ram[addr] and go to RD_LO.
- RD_LO: mem_to_dma_valid=1, mem_out_socket=byte[3:0]. Advance to RD_HI on mem_to_dma_enable.
- RD_HI: drive byte[7:4]. On handshake, increment addr and decrement remaining, then go to DONE if remaining=0, else RD_FETCH.
- DONE: done=1 for exactly one cycle, then IDLE.
- Nibble order is low first, then high, in both directions.
- Address arithmetic is modulo 2^ADDR_W: 0xFF+1 wraps to 0x00 at ADDR_W=8. Length is never wrapped.

## Timing
- Reset values: addr_in_enable=0, dma_to_mem_enable=0, mem_to_dma_valid=0, mem_out_socket=0, busy=0, done=0, state=IDLE.
  - addr_in_enable rises the cycle after reset deasserts.
  - RAM contents are not cleared.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Write latency: descriptor accepted at edge N, dma_to_mem_enable=1 from cycle N+1. A byte is visible in RAM the cycle after its WR_HI handshake.
- Read latency: descriptor at N, RD_FETCH in cycle N+1, first mem_to_dma_valid in cycle N+2. Each later byte costs one fetch cycle (3 cycles per byte at full rate).
- Backpressure: while mem_to_dma_valid=1 and mem_to_dma_enable=0, mem_out_socket holds stable.
- Input ignore rules:
  - dma_to_mem_valid is ignored outside WR states.
  - addr_in_valid is ignored outside IDLE, with no queuing.
- Reset mid-transfer: the partial nibble is discarded, no RAM write for an incomplete byte, no done pulse, return to IDLE.
- Length counter is LEN_W bits. len_in ≥ 2^ADDR_W is legal; the address wraps and overwrites earlier bytes.

## Structure
- Package dma_pkg holds:
  - state enum for the port;
  - NIB_LO_FIRST constant;
  - handshake macro/function fire(valid, enable).
- Sub-module mem_byte_ram: single-port, synchronous-read, 2^ADDR_W×8, write-enable, one-cycle read latency.
- Top holds the FSM, address and length counters, nibble holding register and output registers.

## Test plan
- Write path: mode=1, addr=0x10, len=2, nibbles 3,A,5,C with dma_to_mem_valid held 1 → ram[0x10]=0xA3, ram[0x11]=0xC5; done pulses once, on the cycle after the 4th handshake.
- Read with backpressure: preload ram[0x20]=0x7E, mode=0, addr=0x20, len=1, mem_to_dma_enable low for 3 cycles → nibble E is held stable through the stall, then 7 follows; done pulses once.
- Address wrap: mode=1, addr=0xFF, len=2, bytes 0x11 and 0x22 → ram[0xFF]=0x11, ram[0x00]=0x22.
- Zero length: len=0 → no data enables asserted, done pulses 1 cycle after accept, addr_in_enable returns to 1 one cycle after the done cycle.
- Reset mid-transfer: mode=1, len=4, assert resetn after the 3rd nibble → ram[addr+1] is unchanged, no done pulse, all outputs at their reset values the next cycle.
- Random handshakes: random valid/enable toggling across 64 bytes → read-back stream equals the written stream, exactly 2 handshakes per byte.
